ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage MIPS pipeline, directly upstream of the MEM stage.
//  - Forwarding muxes feed a single-cycle ALU.
//  - An iterative 32-cycle MULTU/DIVU unit owns the HI/LO registers.
//  - The EX/MEM pipeline register drives the MEM stage inputs.
//  - stall_o freezes IF/ID/EX while the mult/div unit is busy.
// PARAMETERS
//  DATA_W      32  datapath width; only 32 is supported
//  REG_ADDR_W  5   register-number width
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   synchronous, active-high reset
//  RegWrite_i    in   1   ID/EX control: writes a GPR
//  MemtoReg_i    in   1   ID/EX control: WB takes memory data
//  MemRead_i     in   1   ID/EX control: lw
//  MemWrite_i    in   1   ID/EX control: sw
//  ALUSrc_i      in   1   1: ALU B operand = imm_i
//  RegDst_i      in   1   1: dest = rd_addr_i, 0: dest = rt_addr_i
//  ALUOp_i       in   4   operation code; see BEHAVIOUR
//  rs_data_i     in   32  register-file rs value
//  rt_data_i     in   32  register-file rt value
//  imm_i         in   32  immediate, already extended
//  rt_addr_i     in   5   rt register number
//  rd_addr_i     in   5   rd register number
//  ForwardA_i    in   2   rs source: 00 reg, 01 WB, 10 MEM, 11 reg
//  ForwardB_i    in   2   rt source, same encoding as ForwardA_i
//  mem_fwd_i     in   32  EX/MEM ALU result (forward source)
//  wb_fwd_i      in   32  MEM/WB writeback data (forward source)
//  stall_o       out  1   comb.; hold PC, IF/ID and ID/EX
//  RegWrite_o    out  1   registered EX/MEM control
//  MemtoReg_o    out  1   registered EX/MEM control
//  MemRead_o     out  1   registered EX/MEM control
//  MemWrite_o    out  1   registered EX/MEM control
//  ALU_result_o  out  32  registered ALU result / memory address
//  rt_data_o     out  32  registered forwarded rt value (sw data)
//  dest_reg_o    out  5   registered destination register
// BEHAVIOUR
//  Operands
//  - A = fwd(ForwardA_i, rs); Bf = fwd(ForwardB_i, rt); B = ALUSrc_i ? imm_i : Bf.
//  ALUOp_i
//  - 0 ADD, 1 SUB: wrap modulo 2^32, no overflow trap.
//  - 2 AND, 3 OR, 4 XOR, 5 NOR.
//  - 6 SLT: signed compare, result 1/0.
//  - 7 SLTU: unsigned compare, result 1/0.
//  - 8 MULTU, 9 DIVU: start the mult/div unit.
//  - A MFHI: result = HI.
//  - B MFLO: result = LO.
//  - C..F: result 0.
//  Reset (synchronous, active-high)
//  - All EX/MEM outputs clear to 0; HI = LO = 0; FSM goes to IDLE; stall_o = 0.
//  - Reset mid-operation aborts the mult/div unit; HI/LO are not updated by it.
//  EX/MEM register
//  - Loads every cycle from the current EX results.
//  - When stall_o = 1 or the FSM is in DONE, it loads a bubble:
//    all four control bits 0, data fields 0.
//  FSM: IDLE -> BUSY -> DONE -> IDLE
//  - IDLE with ALUOp 8 or 9:
//    - latch A, Bf and the op;
//    - cnt = 0;
//    - go to BUSY.
//  - BUSY:
//    - one shift-add (MULTU) or restoring-subtract (DIVU) step per cycle;
//    - cnt increments each step;
//    - at cnt = 31, write HI/LO and go to DONE.
//  - DONE: one cycle, stall_o = 0.
//    - The held MULTU/DIVU retires as a bubble.
//    - Next state is IDLE; this prevents a re-issue.
//  - stall_o = (IDLE && ALUOp in {8,9}) || BUSY.
//    - This is 33 stalled cycles per mult/div.
//  Results
//  - MULTU: {HI, LO} = 64-bit unsigned product.
//  - DIVU: LO = quotient, HI = remainder.
//  - DIVU with divisor 0: LO = 32'hFFFFFFFF, HI = dividend.
//  - MFHI/MFLO see HI/LO from the cycle after the write, so a MFLO following
//    a MULTU reads the new value.
//  Forwarding
//  - Forward inputs are ignored in BUSY because operands were latched at issue.
// TESTING
//  - ForwardA=10, mem_fwd=5, rt=3, ADD -> next cycle ALU_result_o=8, RegWrite_o=1.
//  - MULTU 7,6 then MFLO:
//    - stall_o high exactly 33 cycles;
//    - EX/MEM holds bubbles during the stall;
//    - MFLO produces ALU_result_o=42; HI=0.
//  - DIVU 100,7 then MFLO, MFHI -> 14, then 2.
//  - DIVU 9,0 -> LO=FFFFFFFF, HI=9.
//  - SLT -1,1 -> 1; SLTU -1,1 -> 0; sw with ForwardB=01 -> rt_data_o=wb_fwd_i.
//  - rst asserted at BUSY cnt=10 -> next cycle stall_o=0, HI=LO=0, all outputs 0.

Source files
------------

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding muxes, single-cycle ALU, iterative MULTU/DIVU
// unit owning HI/LO, and the EX/MEM pipeline register.
module ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWrite_i,
    input  logic                  MemtoReg_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic                  ALUSrc_i,
    input  logic                  RegDst_i,
    input  logic [3:0]            ALUOp_i,
    input  logic [DATA_W-1:0]     rs_data_i,
    input  logic [DATA_W-1:0]     rt_data_i,
    input  logic [DATA_W-1:0]     imm_i,
    input  logic [REG_ADDR_W-1:0] rt_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic [1:0]            ForwardA_i,
    input  logic [1:0]            ForwardB_i,
    input  logic [DATA_W-1:0]     mem_fwd_i,
    input  logic [DATA_W-1:0]     wb_fwd_i,
    output logic                  stall_o,
    output logic                  RegWrite_o,
    output logic                  MemtoReg_o,
    output logic                  MemRead_o,
    output logic                  MemWrite_o,
    output logic [DATA_W-1:0]     ALU_result_o,
    output logic [DATA_W-1:0]     rt_data_o,
    output logic [REG_ADDR_W-1:0] dest_reg_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdState_t;

    mdState_t                r_state;
    mdState_t                w_nextState;
    logic [4:0]              r_cnt;
    logic                    r_isDiv;
    logic [DATA_W-1:0]       r_operand;
    logic [2*DATA_W-1:0]     r_acc;
    logic [DATA_W-1:0]       r_hi;
    logic [DATA_W-1:0]       r_lo;

    logic [DATA_W-1:0]       w_opA;
    logic [DATA_W-1:0]       w_opBf;
    logic [DATA_W-1:0]       w_opB;
    logic [DATA_W-1:0]       w_aluResult;
    logic                    w_isMulDiv;
    logic                    w_bubble;
    logic [DATA_W:0]         w_mulSum;
    logic [2*DATA_W-1:0]     w_mulNext;
    logic [DATA_W:0]         w_divTrial;
    logic                    w_divTake;
    logic [2*DATA_W-1:0]     w_divNext;
    logic [2*DATA_W-1:0]     w_stepNext;

    always_comb begin
        w_opA = rs_data_i;
        case (ForwardA_i)
            2'b01:   w_opA = wb_fwd_i;
            2'b10:   w_opA = mem_fwd_i;
            default: w_opA = rs_data_i;
        endcase
        w_opBf = rt_data_i;
        case (ForwardB_i)
            2'b01:   w_opBf = wb_fwd_i;
            2'b10:   w_opBf = mem_fwd_i;
            default: w_opBf = rt_data_i;
        endcase
        w_opB = ALUSrc_i ? imm_i : w_opBf;
    end

    always_comb begin
        w_aluResult = '0;
        case (ALUOp_i)
            4'h0: w_aluResult = w_opA + w_opB;
            4'h1: w_aluResult = w_opA - w_opB;
            4'h2: w_aluResult = w_opA & w_opB;
            4'h3: w_aluResult = w_opA | w_opB;
            4'h4: w_aluResult = w_opA ^ w_opB;
            4'h5: w_aluResult = ~(w_opA | w_opB);
            4'h6: w_aluResult = {{(DATA_W-1){1'b0}}, ($signed(w_opA) < $signed(w_opB))};
            4'h7: w_aluResult = {{(DATA_W-1){1'b0}}, (w_opA < w_opB)};
            4'hA: w_aluResult = r_hi;
            4'hB: w_aluResult = r_lo;
            default: w_aluResult = '0;
        endcase
    end

    // r_acc holds {partial product, multiplier} for MULTU and {remainder, dividend/quotient} for DIVU
    always_comb begin
        w_mulSum   = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_operand} : '0);
        w_mulNext  = {w_mulSum, r_acc[DATA_W-1:1]};
        w_divTrial = r_acc[2*DATA_W-1:DATA_W-1] - {1'b0, r_operand};
        w_divTake  = !w_divTrial[DATA_W] || (r_operand == '0);
        w_divNext  = w_divTake ? {w_divTrial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1}
                               : {r_acc[2*DATA_W-2:0], 1'b0};
        w_stepNext = r_isDiv ? w_divNext : w_mulNext;
    end

    always_comb begin
        w_isMulDiv  = (ALUOp_i == 4'h8) || (ALUOp_i == 4'h9);
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_isMulDiv) w_nextState = BUSY;
            BUSY:    if (r_cnt == 5'd31) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
        stall_o  = !rst && (((r_state == IDLE) && w_isMulDiv) || (r_state == BUSY));
        w_bubble = stall_o || (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_isDiv   <= 1'b0;
            r_operand <= '0;
            r_acc     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_isMulDiv) begin
                        r_cnt   <= '0;
                        r_isDiv <= (ALUOp_i == 4'h9);
                        if (ALUOp_i == 4'h9) begin
                            r_operand <= w_opBf;
                            r_acc     <= {{DATA_W{1'b0}}, w_opA};
                        end else begin
                            r_operand <= w_opA;
                            r_acc     <= {{DATA_W{1'b0}}, w_opBf};
                        end
                    end
                end
                BUSY: begin
                    r_acc <= w_stepNext;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_hi <= w_stepNext[2*DATA_W-1:DATA_W];
                        r_lo <= w_stepNext[DATA_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // A held mult/div instruction retires as a bubble, including its DONE cycle
    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            RegWrite_o   <= 1'b0;
            MemtoReg_o   <= 1'b0;
            MemRead_o    <= 1'b0;
            MemWrite_o   <= 1'b0;
            ALU_result_o <= '0;
            rt_data_o    <= '0;
            dest_reg_o   <= '0;
        end else begin
            RegWrite_o   <= RegWrite_i;
            MemtoReg_o   <= MemtoReg_i;
            MemRead_o    <= MemRead_i;
            MemWrite_o   <= MemWrite_i;
            ALU_result_o <= w_aluResult;
            rt_data_o    <= w_opBf;
            dest_reg_o   <= RegDst_i ? rd_addr_i : rt_addr_i;
        end
    end

endmodule
